// File: rtl/data_mem_unit.sv
// Word-addressed data memory with a request/response load port and a fixed,
// parameterised load latency. Stores complete in the accepting cycle.
//
// Handshake: a request moves on a rising edge with req_valid && req_ready, and
// a load result moves on a rising edge with resp_valid && resp_ready. A producer
// holding valid keeps its payload stable until that edge.
module data_mem_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int LD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_ld,
  input  logic              req_st,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              st_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0]      CNT_INIT = 2'(LD_LAT - 1);

  // Contents survive reset on purpose; only power-up starts them at zero.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic [DATA_W-1:0] pend_data_q;
  logic              pend_err_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_err_q;
  logic              st_err_q;

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_data;
  logic              accept;

  assign in_range = ({1'b0, req_addr} < DEPTH_X);
  assign idx      = req_addr[IDX_W-1:0];
  assign rd_data  = in_range ? mem_q[idx] : '0;
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Load wins when both ld and st are set, so the store path excludes req_ld.
  always_ff @(posedge clk) begin
    if (accept && req_st && !req_ld && in_range) begin
      mem_q[idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      pend_data_q  <= '0;
      pend_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      st_err_q     <= 1'b0;
    end else begin
      st_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (req_ld) begin
              if (LD_LAT == 1) begin
                state_q      <= RESP;
                resp_valid_q <= 1'b1;
                resp_data_q  <= rd_data;
                resp_err_q   <= !in_range;
              end else begin
                state_q     <= WAIT;
                cnt_q       <= CNT_INIT;
                pend_data_q <= rd_data;
                pend_err_q  <= !in_range;
              end
            end else if (req_st && !in_range) begin
              st_err_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= pend_data_q;
            resp_err_q   <= pend_err_q;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign st_err     = st_err_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of words held.
REQ-003 SHALL have parameter ADDR_W, default 5, request address width; legal when 2^ADDR_W >= DEPTH.
REQ-004 SHALL have parameter LD_LAT, default 1, load latency in cycles; legal range 1..4.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-009 SHALL have port req_ld  input  1  request is a load.
REQ-010 SHALL have port req_st  input  1  request is a store.
REQ-011 SHALL have port req_addr  input  ADDR_W  word address (ALU result).
REQ-012 SHALL have port req_wdata  input  DATA_W  store data (op2).
REQ-013 SHALL have port resp_valid  output  1  load result available.
REQ-014 SHALL have port resp_ready  input  1  consumer takes load result.
REQ-015 SHALL have port resp_data  output  DATA_W  load result.
REQ-016 SHALL have port resp_err  output  1  load address was out of range.
REQ-017 SHALL have port st_err  output  1  one-cycle pulse: store address was out of range.

Function
REQ-018 SHALL hold DEPTH words of DATA_W bits in an internal array, all zero at time 0; the array SHALL NOT be cleared by rst.
REQ-019 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1; no other edge accepts.
REQ-020 SHALL drive req_ready=1 only in state IDLE with rst=0.
REQ-021 SHALL treat req_ld=1 with req_st=1 as a load only (store ignored); req_ld=0 with req_st=0 accepted as no-op.
REQ-022 Store, req_addr < DEPTH: SHALL write req_wdata to array[req_addr] at the acceptance edge; state stays IDLE; next request acceptable the following cycle.
REQ-023 Store, req_addr >= DEPTH: SHALL leave the array unchanged and assert st_err for exactly the one cycle after the acceptance edge.
REQ-024 Load: SHALL capture array[req_addr] (or 0 with error flag if req_addr >= DEPTH) at the acceptance edge.
REQ-025 FSM states IDLE, WAIT, RESP: IDLE->RESP on load accept if LD_LAT=1; IDLE->WAIT with counter=LD_LAT-1 if LD_LAT>1.
REQ-026 WAIT: counter decrements each cycle; on the edge where counter is 1, SHALL move to RESP.
REQ-027 resp_valid SHALL rise exactly LD_LAT cycles after the acceptance edge and be 1 only in RESP.
REQ-028 RESP: resp_data/resp_err SHALL hold stable until the edge with resp_ready=1, then go to IDLE; resp_ready low indefinitely stalls with no data change.
REQ-029 resp_data and resp_err SHALL be 0 whenever resp_valid=0.
REQ-030 Minimum load-to-load spacing SHALL be LD_LAT+1 cycles with resp_ready held 1.
REQ-031 resp_ready while not in RESP SHALL be ignored.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, counter 0, resp_valid 0, resp_data 0, resp_err 0, st_err 0, req_ready 0 while rst is high.
REQ-033 rst asserted during WAIT or RESP SHALL abort the pending load; no response is produced after release.
REQ-034 A store accepted on the edge before rst rises SHALL remain in the array.

Verification
REQ-035 Store addr 3 data 16'hBEEF, then load addr 3, LD_LAT=1, resp_ready=1 -> resp_valid one cycle after load accept, resp_data=16'hBEEF, resp_err=0.
REQ-036 LD_LAT=3, load addr 0 after reset -> resp_valid at cycle 3 after accept, resp_data=16'h0000, req_ready=0 in cycles 1..3.
REQ-037 Load addr 40 with ADDR_W=6, DEPTH=32 -> resp_err=1, resp_data=0; store addr 40 -> st_err pulse one cycle, array unchanged (reload addr 8 returns prior value).
REQ-038 Load addr 5 (holding 16'h1234), resp_ready=0 for 5 cycles -> resp_valid and resp_data=16'h1234 stable all 5 cycles, IDLE after resp_ready=1.
REQ-039 req_ld=req_st=1, addr 7, wdata 16'hAAAA, array[7]=16'h0055 -> response 16'h0055, array[7] still 16'h0055.
REQ-040 rst pulsed mid-WAIT (LD_LAT=4) -> resp_valid never asserts for that load; previously stored values intact.
